// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the data memory bridge
package core_pkg;

    localparam int WORD_W = 32;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmb_state_t;

    // Word accesses only: the two low byte-address bits must be zero.
    function automatic logic is_aligned(input logic [WORD_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/dmb_timeout.sv
// rtl/dmb_timeout.sv - saturating bus-acknowledge timeout counter
module dmb_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    // Count unacknowledged request cycles; hold once the limit is reached.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= 8'd0;
        end else if (enable && !expired) begin
            count <= count + 8'd1;
        end
    end

    // The counter reads 0 in the first request cycle, so TIMEOUT-1 marks the last one.
    assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - core data port to req/ack data memory bus bridge
module data_mem_bridge
    import core_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_enable,
    input  logic              mem_r_w,
    input  logic [WORD_W-1:0] mem_address,
    input  logic [WORD_W-1:0] mem_input,
    output logic [WORD_W-1:0] mem_output,
    output logic              mem_stall,
    output logic              mem_done,
    output logic              mem_error,
    output logic              bus_req,
    output logic              bus_we,
    output logic [WORD_W-1:0] bus_addr,
    output logic [WORD_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [WORD_W-1:0] bus_rdata
);

    dmb_state_t state;
    logic       err_flag;
    logic       tmo_clear;
    logic       tmo_enable;
    logic       tmo_expired;

    // The counter sits at zero whenever idle, so it starts fresh on every REQ entry.
    assign tmo_clear  = (state == IDLE);
    assign tmo_enable = (state == REQ) && !bus_ack;

    dmb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // Access sequencing: accept in IDLE, wait for ack or timeout in REQ, report in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            err_flag   <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            mem_output <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_enable) begin
                        if (is_aligned(mem_address)) begin
                            bus_addr  <= mem_address;
                            bus_wdata <= mem_input;
                            bus_we    <= (mem_r_w == MEM_WRITE);
                            bus_req   <= 1'b1;
                            err_flag  <= 1'b0;
                            state     <= REQ;
                        end else begin
                            err_flag <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        if (!bus_we) begin
                            mem_output <= bus_rdata;
                        end
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end else if (tmo_expired) begin
                        if (!bus_we) begin
                            mem_output <= '0;
                        end
                        bus_req  <= 1'b0;
                        err_flag <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Completion is a pure decode of DONE; the core is released in exactly that cycle.
    assign mem_done  = (state == DONE);
    assign mem_error = mem_done & err_flag;
    assign mem_stall = mem_enable & ~mem_done;

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb/tb_data_mem_bridge.sv - scoreboard bench for data_mem_bridge
module tb_data_mem_bridge;
    import core_pkg::*;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_enable;
    logic        mem_r_w;
    logic [31:0] mem_address;
    logic [31:0] mem_input;
    logic [31:0] mem_output;
    logic        mem_stall;
    logic        mem_done;
    logic        mem_error;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    data_mem_bridge #(
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_enable  (mem_enable),
        .mem_r_w     (mem_r_w),
        .mem_address (mem_address),
        .mem_input   (mem_input),
        .mem_output  (mem_output),
        .mem_stall   (mem_stall),
        .mem_done    (mem_done),
        .mem_error   (mem_error),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    typedef struct {
        int          done_cyc;
        logic        err;
        logic [31:0] out;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] model_out = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Completion monitor: every mem_done pops one scoreboard entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mem_done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {31'b0, mem_done}, 32'h0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", cyc, e.done_cyc);
                check("done_error", {31'b0, mem_error}, {31'b0, e.err});
                check("done_output", mem_output, e.out);
            end
        end else if (mem_error === 1'b1) begin
            check("error_without_done", {31'b0, mem_error}, 32'h0);
        end
    end

    // One core access; entered and left just after a rising edge. ack_k=0 means never ack.
    task automatic access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ack_k);
        int   start;
        int   last_req;
        int   d;
        exp_t e;
        start       = cyc;
        mem_enable  = 1'b1;
        mem_r_w     = rw;
        mem_address = addr;
        mem_input   = wdata;
        if (addr[1:0] != 2'b00) begin
            last_req = 0;
            d        = 1;
            e.err    = 1'b1;
        end else if (ack_k > 0) begin
            last_req = ack_k;
            d        = ack_k + 1;
            e.err    = 1'b0;
            if (rw) model_out = rdata;
        end else begin
            last_req = TMO;
            d        = TMO + 1;
            e.err    = 1'b1;
            if (rw) model_out = 32'h0;
        end
        e.out      = model_out;
        e.done_cyc = start + d;
        sb.push_back(e);
        for (int c = 0; c <= d; c++) begin
            bus_ack   = (ack_k > 0) && (c == ack_k);
            bus_rdata = bus_ack ? rdata : $urandom;
            @(negedge clk);
            check($sformatf("bus_req_c%0d", c), {31'b0, bus_req}, {31'b0, (c >= 1 && c <= last_req)});
            check($sformatf("stall_c%0d", c), {31'b0, mem_stall}, {31'b0, (c < d)});
            if (c >= 1 && c <= last_req) begin
                check($sformatf("bus_addr_c%0d", c), bus_addr, addr);
                check($sformatf("bus_wdata_c%0d", c), bus_wdata, wdata);
                check($sformatf("bus_we_c%0d", c), {31'b0, bus_we}, {31'b0, ~rw});
            end
            @(posedge clk);
            #1;
        end
        bus_ack    = 1'b0;
        mem_enable = 1'b0;
    endtask

    task automatic idle(input int n, input logic stray);
        for (int c = 0; c < n; c++) begin
            mem_enable = 1'b0;
            bus_ack    = stray && (c == 0);
            bus_rdata  = $urandom;
            @(negedge clk);
            check("idle_bus_req", {31'b0, bus_req}, 32'h0);
            check("idle_stall", {31'b0, mem_stall}, 32'h0);
            check("idle_output", mem_output, model_out);
            @(posedge clk);
            #1;
        end
        bus_ack = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        mem_enable  = 1'b0;
        mem_r_w     = 1'b0;
        mem_address = 32'h0;
        mem_input   = 32'h0;
        bus_ack     = 1'b0;
        bus_rdata   = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bus_req", {31'b0, bus_req}, 32'h0);
        check("rst_bus_we", {31'b0, bus_we}, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_mem_output", mem_output, 32'h0);
        check("rst_mem_done", {31'b0, mem_done}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2, 1'b0);

        access(MEM_READ, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1);
        idle(1, 1'b0);
        access(MEM_WRITE, 32'h0000_0100, 32'h1234_5678, 32'hFFFF_0000, 3);
        idle(1, 1'b0);
        access(MEM_READ, 32'h0000_0013, 32'h0, 32'h0, 0);
        idle(1, 1'b0);
        access(MEM_READ, 32'h0000_0020, 32'h0, 32'h0, 0);
        idle(1, 1'b0);

        // Reset lands during cycle 2 of a read that would otherwise time out.
        mem_enable  = 1'b1;
        mem_r_w     = MEM_READ;
        mem_address = 32'h0000_0040;
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            check($sformatf("rstmid_bus_req_c%0d", c), {31'b0, bus_req}, {31'b0, (c >= 1)});
            if (c < 2) begin
                @(posedge clk);
                #1;
            end
        end
        reset      = 1'b1;
        mem_enable = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        model_out = 32'h0;
        @(negedge clk);
        check("rstmid_bus_req_c3", {31'b0, bus_req}, 32'h0);
        check("rstmid_done_c3", {31'b0, mem_done}, 32'h0);
        @(posedge clk);
        #1;
        idle(3, 1'b0);
        access(MEM_READ, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 2);

        // Core holds its request across DONE into the next access.
        access(MEM_READ, 32'h0000_0200, 32'h0, 32'hA5A5_0001, 1);
        access(MEM_READ, 32'h0000_0204, 32'h0, 32'h5A5A_0002, 2);
        idle(3, 1'b1);
        access(MEM_WRITE, 32'h0000_0300, 32'h0BAD_CAFE, 32'h1111_2222, 1);
        idle(2, 1'b0);

        check("sb_empty", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
